deserializer: RTL and testbench

DESERIALIZER -- requirements
Module: deserializer

---
 rtl/ser_pkg.sv | 12 +
 rtl/deserializer.sv | 101 ++++++++++
 tb/tb_deserializer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// Constants and state type shared by the serializer/deserializer pair.
package ser_pkg;

    localparam int SER_WORD_LEN = 16;
    localparam int SER_MOD_W    = 4;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_RECV = 1'b1
    } ser_state_e;

endpackage

// File: rtl/deserializer.sv
// Serial-to-parallel converter, MSB first, with one-cycle output strobe.
// Optional short-word flush on data_last_i enabled by macro DESERIALIZER_FLUSH_EN.
module deserializer
    import ser_pkg::*;
#(
    parameter int WORD_LEN = SER_WORD_LEN
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    input  logic                 data_i,
    input  logic                 data_val_i,
    input  logic                 data_last_i,
    output logic [WORD_LEN-1:0]  deser_data_o,
    output logic [SER_MOD_W-1:0] deser_data_mod_o,
    output logic                 deser_data_val_o,
    output logic                 busy_o
);

    localparam int CW = $clog2(WORD_LEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(WORD_LEN - 1);

    ser_state_e                state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    // Only WORD_LEN-1 bits are ever held; the final bit goes straight to the output.
    logic [WORD_LEN-2:0]       sr_q, sr_d;
    logic [WORD_LEN-1:0]       data_q, data_d;
    logic [SER_MOD_W-1:0]      mod_q, mod_d;
    logic                      val_q, val_d;

    logic [WORD_LEN-1:0]       shifted;
    logic                      flush;
    logic                      word_end;

`ifdef DESERIALIZER_FLUSH_EN
    localparam logic [CW:0] FULL_N = (CW+1)'(WORD_LEN);
    logic [CW:0] n_bits;

    assign flush  = data_last_i;
    assign n_bits = {1'b0, cnt_q} + 1'b1;
`else
    logic unused_last;

    assign flush       = 1'b0;
    assign unused_last = data_last_i;
`endif

    assign shifted  = {sr_q, data_i};
    assign word_end = (cnt_q == LAST_IDX) || flush;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        data_d  = data_q;
        mod_d   = mod_q;
        val_d   = 1'b0;
        if (data_val_i) begin
            if (word_end) begin
                // Register cleared between words, so a flushed word is already right-aligned.
                data_d  = shifted;
                val_d   = 1'b1;
`ifdef DESERIALIZER_FLUSH_EN
                mod_d   = (n_bits == FULL_N) ? '0 : SER_MOD_W'(n_bits);
`else
                mod_d   = '0;
`endif
                sr_d    = '0;
                cnt_d   = '0;
                state_d = SER_IDLE;
            end else begin
                sr_d    = shifted[WORD_LEN-2:0];
                cnt_d   = cnt_q + 1'b1;
                state_d = SER_RECV;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= SER_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            mod_q   <= '0;
            val_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            mod_q   <= mod_d;
            val_q   <= val_d;
        end
    end

    assign deser_data_o     = data_q;
    assign deser_data_mod_o = mod_q;
    assign deser_data_val_o = val_q;
    assign busy_o           = (state_q == SER_RECV);

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: directed word scenarios plus random traffic
// compared every cycle against an arithmetic reference model.
module tb_deserializer;

    logic        clk = 1'b0;
    logic        srst_i = 1'b1;
    logic        data_i = 1'b0;
    logic        data_val_i = 1'b0;
    logic        data_last_i = 1'b0;
    logic [15:0] deser_data_o;
    logic [3:0]  deser_data_mod_o;
    logic        deser_data_val_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int cyc_cnt = 0;
    bit chk_en = 1'b0;

`ifdef DESERIALIZER_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    deserializer #(.WORD_LEN(16)) dut (
        .clk_i           (clk),
        .srst_i          (srst_i),
        .data_i          (data_i),
        .data_val_i      (data_val_i),
        .data_last_i     (data_last_i),
        .deser_data_o    (deser_data_o),
        .deser_data_mod_o(deser_data_mod_o),
        .deser_data_val_o(deser_data_val_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: bits held counted as an integer, word accumulated as value*2+bit.
    int          m_cnt = 0;
    int          m_acc = 0;
    logic        e_val = 1'b0;
    logic [15:0] e_data = '0;
    logic [3:0]  e_mod = '0;
    logic        e_busy = 1'b0;

    always @(posedge clk) begin : model
        int n;
        int w;
        n = m_cnt;
        w = m_acc;
        cyc_cnt <= cyc_cnt + 1;
        if (srst_i) begin
            m_cnt  <= 0;
            m_acc  <= 0;
            e_val  <= 1'b0;
            e_data <= '0;
            e_mod  <= '0;
            e_busy <= 1'b0;
        end else begin
            e_val <= 1'b0;
            if (data_val_i) begin
                n = n + 1;
                w = w * 2 + int'(data_i);
                if (n == 16 || (FLUSH && data_last_i)) begin
                    e_val  <= 1'b1;
                    e_data <= w[15:0];
                    e_mod  <= (n == 16) ? 4'd0 : n[3:0];
                    n = 0;
                    w = 0;
                end
            end
            m_cnt  <= n;
            m_acc  <= w;
            e_busy <= (n != 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("val", {31'b0, deser_data_val_o}, {31'b0, e_val});
            chk("data", {16'b0, deser_data_o}, {16'b0, e_data});
            chk("mod", {28'b0, deser_data_mod_o}, {28'b0, e_mod});
            chk("busy", {31'b0, busy_o}, {31'b0, e_busy});
            if (deser_data_val_o) pulses++;
        end
    end

    task automatic cyc(input logic b, input logic v, input logic l);
        data_i      = b;
        data_val_i  = v;
        data_last_i = l;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        srst_i = 1'b1;
        cyc(1'b1, 1'b1, 1'b1);
        srst_i = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input bit gaps);
        for (int i = 15; i >= 0; i--) begin
            cyc(w[i], 1'b1, 1'b0);
            if (gaps && i != 0) cyc(1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)));
        end
    endtask

    initial begin
        int p0, t1, t2;
        logic [15:0] w;
        srst_i = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        srst_i = 1'b0;
        chk_en = 1'b1;
        chk("rst_data", {16'b0, deser_data_o}, 32'h0);
        chk("rst_mod", {28'b0, deser_data_mod_o}, 32'h0);
        chk("rst_val", {31'b0, deser_data_val_o}, 32'h0);
        chk("rst_busy", {31'b0, busy_o}, 32'h0);

        // Contiguous word
        send_word(16'hA5C3, 1'b0);
        chk("w1_val", {31'b0, deser_data_val_o}, 32'h1);
        chk("w1_data", {16'b0, deser_data_o}, 32'hA5C3);
        chk("w1_mod", {28'b0, deser_data_mod_o}, 32'h0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("w1_val_drop", {31'b0, deser_data_val_o}, 32'h0);
        chk("w1_hold", {16'b0, deser_data_o}, 32'hA5C3);

        // Same word with valid low every other cycle
        p0 = pulses;
        send_word(16'hA5C3, 1'b1);
        chk("w2_val", {31'b0, deser_data_val_o}, 32'h1);
        chk("w2_data", {16'b0, deser_data_o}, 32'hA5C3);
        cyc(1'b0, 1'b0, 1'b0);
        chk("w2_pulses", pulses - p0, 32'd1);

        // Back-to-back words
        send_word(16'h1234, 1'b0);
        t1 = cyc_cnt;
        chk("b2b_d1", {16'b0, deser_data_o}, 32'h1234);
        chk("b2b_v1", {31'b0, deser_data_val_o}, 32'h1);
        w = 16'hFFFF;
        for (int i = 15; i >= 0; i--) begin
            cyc(w[i], 1'b1, 1'b0);
            if (i != 0) chk("b2b_busy", {31'b0, busy_o}, 32'h1);
        end
        t2 = cyc_cnt;
        chk("b2b_d2", {16'b0, deser_data_o}, 32'hFFFF);
        chk("b2b_v2", {31'b0, deser_data_val_o}, 32'h1);
        chk("b2b_gap", t2 - t1, 32'd16);

        // Reset mid-word
        cyc(1'b0, 1'b0, 1'b0);
        p0 = pulses;
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0);
        do_reset();
        chk("mid_rst_busy", {31'b0, busy_o}, 32'h0);
        chk("mid_rst_data", {16'b0, deser_data_o}, 32'h0);
        send_word(16'h0F0F, 1'b0);
        chk("after_rst_data", {16'b0, deser_data_o}, 32'h0F0F);
        cyc(1'b0, 1'b0, 1'b0);
        chk("after_rst_pulses", pulses - p0, 32'd1);

        // Short word ending on data_last_i
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
`ifdef DESERIALIZER_FLUSH_EN
        chk("flush_data", {16'b0, deser_data_o}, 32'h0016);
        chk("flush_mod", {28'b0, deser_data_mod_o}, 32'd5);
        chk("flush_val", {31'b0, deser_data_val_o}, 32'h1);
        chk("flush_busy", {31'b0, busy_o}, 32'h0);

        // data_last_i without valid must not end the word
        w = 16'hBEEF;
        p0 = pulses;
        for (int i = 15; i >= 11; i--) cyc(w[i], 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("lastnv_val", {31'b0, deser_data_val_o}, 32'h0);
        chk("lastnv_busy", {31'b0, busy_o}, 32'h1);
        for (int i = 10; i >= 0; i--) cyc(w[i], 1'b1, 1'b0);
        chk("lastnv_data", {16'b0, deser_data_o}, 32'hBEEF);
        chk("lastnv_mod", {28'b0, deser_data_mod_o}, 32'h0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("lastnv_pulses", pulses - p0, 32'd1);
`else
        chk("nofl_val", {31'b0, deser_data_val_o}, 32'h0);
        chk("nofl_busy", {31'b0, busy_o}, 32'h1);
        do_reset();
`endif

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            srst_i = ($urandom_range(199) == 0);
            cyc(1'($urandom_range(1)), ($urandom_range(9) < 7), ($urandom_range(9) == 0));
        end
        srst_i = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
